demux32_4_buf: RTL and testbench
================================

// Module: demux32_4_buf
// PURPOSE
// - Buffered 1-to-4 demultiplexer: inverse of the 4:1 result mux. Accepts one tagged word per cycle
//   on a valid/ready input and steers it into one of four independent per-channel FIFOs.
// - Each channel presents its own valid/ready output.
// - Sits between a producer (e.g. a write-back/result source) and up to four consumers that may stall
//   independently; one stalled consumer blocks only words tagged for it.
// PARAMETERS
// - WIDTH  32  data width of every channel
// - DEPTH  2   entries per channel FIFO; power of two, >= 2
// PORTS
// - clk_i        in   1          single clock, all state updates on rising edge
// - rst_i        in   1          synchronous reset, active-high
// - in_valid     in   1          producer offers in_data/control this cycle
// - in_ready     out  1          slot available for channel 'control'
// - in_data      in   WIDTH      word to route
// - control      in   2          destination channel 0..3
// - out_valid    out  4          bit n: channel n FIFO non-empty
// - out_ready    in   4          bit n: consumer n takes head this cycle
// - out0..out3   out  WIDTH each head entry of channel n; 0 when empty
// - drop_cnt     out  8          saturating count of cycles with in_valid & !in_ready
// BEHAVIOUR
// - Reset (rst_i=1 at edge): all FIFOs empty, pointers/counts 0, out_valid=0, out0..3=0, drop_cnt=0;
//   reset overrides any same-cycle push/pop. in_ready is 1 for every control value after reset.
// - in_ready = (count[control] != DEPTH). Combinational from control and state only; never depends on
//   out_ready (no ready pass-through path).
// - Push: in_valid & in_ready at edge -> in_data written at wr_ptr[control]; wr_ptr+1 mod DEPTH.
//   count+1 unless same channel pops the same cycle.
// - Pop: out_valid[n] & out_ready[n] at edge -> rd_ptr[n]+1 mod DEPTH; count-1 unless pushed.
// - Pop on an empty channel (out_ready=1, out_valid=0) is ignored.
// - Simultaneous push+pop on the same channel: count unchanged, both pointers advance.
//   Legal even when full? No: in_ready is already 0 when full, so no push.
// - Latency: word pushed at edge k is visible on outN with out_valid[N]=1 after edge k (one cycle).
//   No bypass when empty.
// - Ordering: FIFO order preserved per channel; no ordering guarantee across channels.
// - outN shows the mem[rd_ptr] value when count!=0, else 0 (no stale data exposed).
// - in_data/control are don't-care when in_valid=0; control is sampled only on accepted cycles.
// - drop_cnt saturates at 255; held until reset.
// - Pointer wrap: log2(DEPTH)-bit pointers wrap naturally. count is log2(DEPTH)+1 bits (0..DEPTH).
// - No state machine beyond per-channel count; channels fully independent except the shared input.
// STRUCTURE
// - Shared package/header: NUM_CH=4, CH_W=2, default WIDTH/DEPTH, drop counter width (8).
// - One sub-module: demux_chan_fifo (WIDTH, DEPTH; push, pop, din, dout, full, empty).
//   Instantiated four times; top decodes control into a one-hot push vector gated by
//   in_valid & in_ready.
// - Top also holds in_ready select (4:1 on full flags) and the drop counter.
// TESTING
// - Reset: hold rst_i 2 cycles -> out_valid=4'b0000, out0..3=0, in_ready=1 for control=0..3, drop_cnt=0.
// - Routing: push 0xAAAA0001/ch1 then 0x55550003/ch3, out_ready=0 -> out_valid=4'b1010,
//   out1=0xAAAA0001, out3=0x55550003.
// - Full/backpressure: push 0x11,0x22 to ch0, out_ready=0 -> in_ready=0 for control=0 and
//   1 for control=2. A third push of 0x33 is refused and drop_cnt=1.
// - Drain order: from that full state, out_ready[0]=1 for 2 cycles -> out0 = 0x11, then 0x22,
//   then out_valid[0]=0 and out0=0.
// - Simultaneous push/pop, same channel: ch2 holds 0x7, push 0x8 while out_ready[2]=1 ->
//   next cycle out2=0x8, count stays 1. Repeat for 5 cycles to cover pointer wrap.
// - Mid-operation reset: ch0 full and ch3 holding one word, assert rst_i with in_valid=1 ->
//   after edge all empty, the pushed word is discarded, drop_cnt=0.

Source files
------------

// File: rtl/demux32_4_buf_pkg.sv
// Shared constants for the buffered 1-to-4 demultiplexer.
//   NUM_CH    : number of output channels
//   CH_W      : width of the channel-select tag
//   DEF_WIDTH : default data width
//   DEF_DEPTH : default per-channel FIFO depth (power of two, >= 2)
//   DROP_W    : width of the saturating drop counter
package demux32_4_buf_pkg;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned CH_W      = 2;
  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 2;
  localparam int unsigned DROP_W    = 8;
endpackage

// File: rtl/demux32_4_buf_chan_fifo.sv
// Single-channel FIFO used by demux32_4_buf.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push, din    : write din at the tail (ignored when full)
//   pop          : advance the head (ignored when empty)
//   dout         : head entry, 0 when empty
//   full, empty  : occupancy flags
module demux_chan_fifo
  import demux32_4_buf_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head is masked so a drained channel never exposes stale data.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/demux32_4_buf.sv
// Buffered 1-to-4 demultiplexer: one tagged word per cycle on a valid/ready
// input is steered into one of four independent channel FIFOs.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   in_valid, in_ready : input handshake; in_ready reflects the channel
//                        selected by control and never depends on out_ready
//   in_data, control   : word and destination channel
//   out_valid[n]       : channel n non-empty
//   out_ready[n]       : consumer n takes the head this cycle
//   out0..out3         : channel heads, 0 when empty
//   drop_cnt           : saturating count of cycles with in_valid & !in_ready
module demux32_4_buf
  import demux32_4_buf_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [CH_W-1:0]   control,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [WIDTH-1:0]  out0,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  output logic [WIDTH-1:0]  out3,
  output logic [DROP_W-1:0] drop_cnt
);

  logic [NUM_CH-1:0] full_v;
  logic [NUM_CH-1:0] empty_v;
  logic [NUM_CH-1:0] push_v;
  logic [NUM_CH-1:0] pop_v;
  logic [WIDTH-1:0]  dout_v [NUM_CH];

  assign in_ready  = ~full_v[control];
  assign out_valid = ~empty_v;
  assign pop_v     = out_valid & out_ready;

  always_comb begin
    push_v = '0;
    if (in_valid && in_ready) push_v[control] = 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    demux_chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push_v[g]),
      .pop   (pop_v[g]),
      .din   (in_data),
      .dout  (dout_v[g]),
      .full  (full_v[g]),
      .empty (empty_v[g])
    );
  end

  assign out0 = dout_v[0];
  assign out1 = dout_v[1];
  assign out2 = dout_v[2];
  assign out3 = dout_v[3];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt <= '0;
    end else if (in_valid && !in_ready && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux32_4_buf.sv
module tb_demux32_4_buf;

  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  control;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out0, out1, out2, out3;
  logic [7:0]  drop_cnt;

  int pass_cnt = 0;
  int total    = 0;

  demux32_4_buf #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: per-channel queues and a drop counter.
  logic [31:0] mq [4][$];
  int          mdrop = 0;
  bit          armed = 0;

  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < 4; n++) mq[n].delete();
      mdrop = 0;
      armed = 1;
    end else begin
      bit acc;
      acc = in_valid && (mq[control].size() < DEPTH);
      for (int n = 0; n < 4; n++)
        if (out_ready[n] && mq[n].size() > 0) void'(mq[n].pop_front());
      if (acc) mq[control].push_back(in_data);
      if (in_valid && !acc && mdrop < 255) mdrop++;
    end
  end

  function automatic logic [31:0] mhead(input int n);
    return (mq[n].size() > 0) ? mq[n][0] : 32'h0;
  endfunction

  always @(negedge clk_i) begin
    if (armed) begin
      logic [3:0] ev;
      for (int n = 0; n < 4; n++) ev[n] = (mq[n].size() > 0);
      chk("m_out_valid", {28'h0, out_valid}, {28'h0, ev});
      chk("m_out0", out0, mhead(0));
      chk("m_out1", out1, mhead(1));
      chk("m_out2", out2, mhead(2));
      chk("m_out3", out3, mhead(3));
      chk("m_in_ready", {31'h0, in_ready}, {31'h0, mq[control].size() < DEPTH});
      chk("m_drop_cnt", {24'h0, drop_cnt}, mdrop);
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic push(input logic [1:0] ch, input logic [31:0] d);
    in_valid = 1'b1;
    control  = ch;
    in_data  = d;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_i     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    control   = '0;
    out_ready = '0;
    cyc();
    cyc();
    rst_i = 1'b0;

    // Reset state
    chk("rst_out_valid", {28'h0, out_valid}, 32'h0);
    chk("rst_out0", out0, 32'h0);
    chk("rst_out3", out3, 32'h0);
    chk("rst_drop", {24'h0, drop_cnt}, 32'h0);
    for (int c = 0; c < 4; c++) begin
      control = 2'(c);
      #1;
      chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    end

    // Routing
    push(2'd1, 32'hAAAA0001);
    push(2'd3, 32'h55550003);
    chk("route_valid", {28'h0, out_valid}, 32'ha);
    chk("route_out1", out1, 32'hAAAA0001);
    chk("route_out3", out3, 32'h55550003);
    out_ready = 4'b1010;
    cyc();
    out_ready = 4'b0000;
    chk("route_drained", {28'h0, out_valid}, 32'h0);

    // Full / backpressure
    push(2'd0, 32'h11);
    push(2'd0, 32'h22);
    control = 2'd0;
    #1;
    chk("full_rdy0", {31'h0, in_ready}, 32'h0);
    control = 2'd2;
    #1;
    chk("full_rdy2", {31'h0, in_ready}, 32'h1);
    push(2'd0, 32'h33);
    chk("full_drop", {24'h0, drop_cnt}, 32'h1);
    chk("full_head", out0, 32'h11);

    // Drain order
    out_ready = 4'b0001;
    cyc();
    chk("drain_2nd", out0, 32'h22);
    cyc();
    out_ready = 4'b0000;
    chk("drain_empty_v", {31'h0, out_valid[0]}, 32'h0);
    chk("drain_empty_d", out0, 32'h0);

    // Simultaneous push/pop on one channel across pointer wrap
    push(2'd2, 32'h7);
    for (int i = 0; i < 5; i++) begin
      out_ready = 4'b0100;
      push(2'd2, 32'(8 + i));
      chk("pp_out2", out2, 32'(8 + i));
      chk("pp_valid", {31'h0, out_valid[2]}, 32'h1);
      control = 2'd2;
      #1;
      chk("pp_not_full", {31'h0, in_ready}, 32'h1);
    end
    cyc();
    out_ready = 4'b0000;
    chk("pp_empty", {31'h0, out_valid[2]}, 32'h0);

    // Drop counter saturation
    push(2'd1, 32'h101);
    push(2'd1, 32'h102);
    in_valid = 1'b1;
    control  = 2'd1;
    in_data  = 32'hDEAD;
    for (int i = 0; i < 260; i++) cyc();
    in_valid = 1'b0;
    chk("drop_sat", {24'h0, drop_cnt}, 32'd255);
    out_ready = 4'b0010;
    cyc();
    cyc();
    out_ready = 4'b0000;

    // Mid-operation reset with an in-flight push
    push(2'd0, 32'hA0);
    push(2'd0, 32'hA1);
    push(2'd3, 32'hB0);
    rst_i    = 1'b1;
    in_valid = 1'b1;
    control  = 2'd0;
    in_data  = 32'hA2;
    out_ready = 4'b1000;
    cyc();
    rst_i     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    chk("mrst_valid", {28'h0, out_valid}, 32'h0);
    chk("mrst_drop", {24'h0, drop_cnt}, 32'h0);
    chk("mrst_out0", out0, 32'h0);
    push(2'd0, 32'hC);
    chk("mrst_after", out0, 32'hC);
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
